// File: rtl/sensor_poll_scheduler.sv
// Round-robin poller sharing one UART request/response link among up to
// eight sensor nodes. Software one-shot commands take priority over the
// rotation. Each transaction sends a 1-byte request and collects a 2-byte
// reply (data, checksum). Bad checksums and timeouts are retried, and one
// result is reported per transaction. A sticky alarm flags any byte that
// arrives while no reply is expected.
module sensor_poll_scheduler #(
    parameter int         NUM_SENSORS   = 8,
    parameter int         TIMEOUT_CLKS  = 100000,
    parameter int         POLL_GAP_CLKS = 1000,
    parameter int         MAX_RETRY     = 2,
    parameter logic [7:0] CHK_KEY       = 8'h37
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic                   cmd_valid,
    input  logic [2:0]             cmd_sensor,
    output logic                   cmd_ready,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    input  logic                   rx_dv,
    input  logic [7:0]             rx_byte,
    output logic                   res_valid,
    output logic [2:0]             res_sensor,
    output logic [7:0]             res_data,
    output logic [1:0]             res_status,
    output logic                   busy,
    output logic                   alarm,
    input  logic                   alarm_clr
);

    // Counter widths; each counter only needs to reach its terminal value
    localparam int TMR_W = (TIMEOUT_CLKS > 1)  ? $clog2(TIMEOUT_CLKS)  : 1;
    localparam int GAP_W = (POLL_GAP_CLKS > 1) ? $clog2(POLL_GAP_CLKS) : 1;
    localparam int RTY_W = (MAX_RETRY > 0)     ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CHK_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_IDX = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_B0,
        WAIT_B1,
        CHECK,
        REPORT,
        GAP
    } state_t;

    state_t state, state_next;

    logic [2:0]       cur_idx;
    logic [2:0]       rr_ptr;
    logic [RTY_W-1:0] retry_cnt;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       data_reg;
    logic [7:0]       chk_reg;

    // Decode results from the next-state logic
    logic       latch_cmd;
    logic       latch_poll;
    logic [2:0] poll_sel;
    logic       fail;
    logic       retry_go;
    logic       go_report;
    logic [2:0] rpt_sensor;
    logic [7:0] rpt_data;
    logic [1:0] rpt_status;
    logic       timed_out;
    logic       alarm_set;

    // Reply is valid when the checksum byte equals data XOR key
    function automatic logic chk_ok(input logic [7:0] data, input logic [7:0] chk);
        return chk == (data ^ CHK_KEY);
    endfunction

    // First set mask bit strictly after ptr, wrapping modulo NUM_SENSORS;
    // a single-bit mask wraps all the way round to the same sensor
    function automatic logic [2:0] next_sensor(input logic [2:0] ptr,
                                               input logic [NUM_SENSORS-1:0] mask);
        logic [2:0]             sel;
        logic                   found;
        logic [NUM_SENSORS-1:0] sh;
        int                     idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            idx = (int'(ptr) + k) % NUM_SENSORS;
            sh  = mask >> idx;
            if (!found && sh[0]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tx_dv     = (state == SEND);
    assign res_valid = (state == REPORT);
    assign tx_byte   = {5'b0, cur_idx};

    assign poll_sel  = next_sensor(rr_ptr, sensor_mask);
    assign timed_out = (timer == TMR_W'(TIMEOUT_CLKS - 1));
    assign alarm_set = rx_dv && (state != WAIT_B0) && (state != WAIT_B1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, including retry/report decisions on a failed attempt
    always_comb begin
        state_next = state;
        latch_cmd  = 1'b0;
        latch_poll = 1'b0;
        fail       = 1'b0;
        retry_go   = 1'b0;
        go_report  = 1'b0;
        rpt_sensor = cur_idx;
        rpt_data   = 8'h00;
        rpt_status = ST_OK;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    if (int'(cmd_sensor) >= NUM_SENSORS) begin
                        go_report  = 1'b1;
                        rpt_sensor = cmd_sensor;
                        rpt_status = ST_BAD_IDX;
                        state_next = REPORT;
                    end else begin
                        state_next = SEND;
                    end
                end else if (enable && (sensor_mask != '0)) begin
                    latch_poll = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_next = WAIT_B0;
                end
            end
            WAIT_B0: begin
                if (rx_dv) begin
                    state_next = WAIT_B1;
                end else if (timed_out) begin
                    fail       = 1'b1;
                    rpt_status = ST_TIMEOUT;
                end
            end
            WAIT_B1: begin
                if (rx_dv) begin
                    state_next = CHECK;
                end else if (timed_out) begin
                    fail       = 1'b1;
                    rpt_status = ST_TIMEOUT;
                end
            end
            CHECK: begin
                if (chk_ok(data_reg, chk_reg)) begin
                    go_report  = 1'b1;
                    rpt_data   = data_reg;
                    rpt_status = ST_OK;
                    state_next = REPORT;
                end else begin
                    fail       = 1'b1;
                    rpt_status = ST_CHK_ERR;
                end
            end
            REPORT: begin
                state_next = (POLL_GAP_CLKS == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(POLL_GAP_CLKS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A failed attempt either retries the same sensor or reports the
        // reason for this, the last, failure
        if (fail) begin
            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                retry_go   = 1'b1;
                state_next = SEND;
            end else begin
                go_report  = 1'b1;
                rpt_data   = 8'h00;
                state_next = REPORT;
            end
        end
    end

    // Transaction datapath: target index, rotation pointer, counters, reply bytes
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_idx   <= 3'd0;
            rr_ptr    <= 3'(NUM_SENSORS - 1);
            retry_cnt <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            data_reg  <= 8'h00;
            chk_reg   <= 8'h00;
        end else begin
            if (latch_cmd) begin
                cur_idx <= cmd_sensor;
            end else if (latch_poll) begin
                cur_idx <= poll_sel;
                rr_ptr  <= poll_sel;
            end

            if (state == WAIT_TX && tx_done) begin
                timer <= '0;
            end else if (state == WAIT_B0 || state == WAIT_B1) begin
                timer <= timer + 1'b1;
            end

            if (state == WAIT_B0 && rx_dv) begin
                data_reg <= rx_byte;
            end
            if (state == WAIT_B1 && rx_dv) begin
                chk_reg <= rx_byte;
            end

            if (state == REPORT) begin
                retry_cnt <= '0;
            end else if (retry_go) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Result registers, loaded as REPORT is entered and held until the next one
    always_ff @(posedge clock) begin
        if (reset) begin
            res_sensor <= 3'd0;
            res_data   <= 8'h00;
            res_status <= 2'b00;
        end else if (go_report) begin
            res_sensor <= rpt_sensor;
            res_data   <= rpt_data;
            res_status <= rpt_status;
        end
    end

    // Sticky unsolicited-byte alarm; a new stray byte beats a clear
    always_ff @(posedge clock) begin
        if (reset) begin
            alarm <= 1'b0;
        end else if (alarm_set) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler. Six sensors are configured so
// that an out-of-range index (7) fits on the 3-bit command port.
module tb_sensor_poll_scheduler;

    localparam int NS = 6;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [NS-1:0] sensor_mask;
    logic          cmd_valid;
    logic [2:0]    cmd_sensor;
    logic          cmd_ready;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          res_valid;
    logic [2:0]    res_sensor;
    logic [7:0]    res_data;
    logic [1:0]    res_status;
    logic          busy;
    logic          alarm;
    logic          alarm_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_cnt   = 0;
    int res_cnt  = 0;

    sensor_poll_scheduler #(
        .NUM_SENSORS  (NS),
        .TIMEOUT_CLKS (50),
        .POLL_GAP_CLKS(4),
        .MAX_RETRY    (2),
        .CHK_KEY      (8'h37)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .sensor_mask(sensor_mask),
        .cmd_valid  (cmd_valid),
        .cmd_sensor (cmd_sensor),
        .cmd_ready  (cmd_ready),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .res_valid  (res_valid),
        .res_sensor (res_sensor),
        .res_data   (res_data),
        .res_status (res_status),
        .busy       (busy),
        .alarm      (alarm),
        .alarm_clr  (alarm_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters, sampled mid-cycle
    always @(negedge clock) begin
        if (tx_dv) tx_cnt <= tx_cnt + 1;
        if (res_valid) res_cnt <= res_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_tx();
        int k = 0;
        while (!tx_dv && k < 400) begin
            tick();
            k++;
        end
        check_val("tx_dv_seen", tx_dv, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        check_val("idle_reached", busy, 1'b0);
    endtask

    // Entered at the negedge where tx_dv is visible; ends at the cycle the
    // result (or the retry request) is expected
    task automatic reply(input logic [7:0] d, input logic [7:0] c, input bit exp_ok,
                         input logic [2:0] sens);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rx_dv   = 1'b1;
        rx_byte = d;
        tick();
        rx_dv = 1'b0;
        tick();
        rx_dv   = 1'b1;
        rx_byte = c;
        tick();
        rx_dv = 1'b0;
        check_val("res_not_early", res_valid, 1'b0);
        tick();
        if (exp_ok) begin
            check_val("res_valid", res_valid, 1'b1);
            check_val("res_sensor", res_sensor, sens);
            check_val("res_data", res_data, d);
            check_val("res_status", res_status, 2'b00);
        end else begin
            check_val("no_res_on_bad_chk", res_valid, 1'b0);
            check_val("retry_tx_dv", tx_dv, 1'b1);
            check_val("retry_tx_byte", tx_byte, {5'b0, sens});
        end
    endtask

    // Silent attempt: the timeout fires 50 clocks after tx_done is sampled,
    // and its consequence is visible one negedge later (51 from the drive)
    task automatic attempt_timeout(input bit last);
        int k;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        k = 1;
        while (!(tx_dv || res_valid) && k < 200) begin
            tick();
            k++;
        end
        check_val("timeout_clks", k, 51);
        if (last) begin
            check_val("to_res_valid", res_valid, 1'b1);
            check_val("to_res_status", res_status, 2'b10);
            check_val("to_res_data", res_data, 8'h00);
            check_val("to_res_sensor", res_sensor, 3'd0);
        end else begin
            check_val("to_retry_tx_dv", tx_dv, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_seq [3];
        int tx0, res0;
        exp_seq[0] = 8'h00;
        exp_seq[1] = 8'h02;
        exp_seq[2] = 8'h00;

        reset       = 1'b1;
        enable      = 1'b0;
        sensor_mask = '0;
        cmd_valid   = 1'b0;
        cmd_sensor  = 3'd0;
        tx_done     = 1'b0;
        rx_dv       = 1'b0;
        rx_byte     = 8'h00;
        alarm_clr   = 1'b0;
        repeat (3) tick();

        // Reset state
        check_val("rst_tx_dv", tx_dv, 1'b0);
        check_val("rst_tx_byte", tx_byte, 8'h00);
        check_val("rst_res_valid", res_valid, 1'b0);
        check_val("rst_res_sensor", res_sensor, 3'd0);
        check_val("rst_res_data", res_data, 8'h00);
        check_val("rst_res_status", res_status, 2'b00);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_alarm", alarm, 1'b0);
        check_val("rst_cmd_ready", cmd_ready, 1'b1);

        // Rotation over mask 0b000101: 0, 2, 0
        sensor_mask = 6'h05;
        enable      = 1'b1;
        reset       = 1'b0;
        tx0 = tx_cnt;
        for (int i = 0; i < 3; i++) begin
            wait_tx();
            check_val("rr_tx_byte", tx_byte, exp_seq[i]);
            if (i == 2) enable = 1'b0;
            reply(8'h5A, 8'h6D, 1'b1, exp_seq[i][2:0]);
        end
        wait_idle();
        check_val("rr_tx_count", tx_cnt - tx0, 3);

        // Checksum failure then good retry on sensor 1
        sensor_mask = 6'h02;
        enable      = 1'b1;
        tx0  = tx_cnt;
        res0 = res_cnt;
        wait_tx();
        check_val("chk_tx_byte", tx_byte, 8'h01);
        enable = 1'b0;
        reply(8'h5A, 8'h00, 1'b0, 3'd1);
        reply(8'h5A, 8'h6D, 1'b1, 3'd1);
        wait_idle();
        check_val("chk_tx_count", tx_cnt - tx0, 2);
        check_val("chk_res_count", res_cnt - res0, 1);

        // No reply at all: three attempts, then timeout status
        sensor_mask = 6'h01;
        enable      = 1'b1;
        tx0 = tx_cnt;
        wait_tx();
        check_val("to_tx_byte", tx_byte, 8'h00);
        enable = 1'b0;
        for (int a = 0; a < 3; a++) begin
            attempt_timeout(a == 2);
        end
        wait_idle();
        check_val("to_tx_count", tx_cnt - tx0, 3);

        // Software command to sensor 3
        cmd_valid  = 1'b1;
        cmd_sensor = 3'd3;
        tick();
        cmd_valid = 1'b0;
        check_val("cmd_tx_dv", tx_dv, 1'b1);
        check_val("cmd_tx_byte", tx_byte, 8'h03);
        check_val("cmd_ready_busy", cmd_ready, 1'b0);
        reply(8'h5A, 8'h6D, 1'b1, 3'd3);

        // Stray bytes during GAP
        tick();
        rx_dv   = 1'b1;
        rx_byte = 8'hAA;
        tick();
        rx_dv = 1'b0;
        check_val("alarm_set", alarm, 1'b1);
        rx_dv     = 1'b1;
        alarm_clr = 1'b1;
        tick();
        rx_dv     = 1'b0;
        alarm_clr = 1'b0;
        check_val("alarm_set_beats_clr", alarm, 1'b1);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check_val("alarm_cleared", alarm, 1'b0);
        wait_idle();

        // Out-of-range index: reported immediately, nothing sent
        tx0 = tx_cnt;
        cmd_valid  = 1'b1;
        cmd_sensor = 3'd7;
        tick();
        cmd_valid = 1'b0;
        check_val("bad_res_valid", res_valid, 1'b1);
        check_val("bad_res_status", res_status, 2'b11);
        check_val("bad_res_sensor", res_sensor, 3'd7);
        check_val("bad_res_data", res_data, 8'h00);
        wait_idle();
        check_val("bad_no_tx", tx_cnt - tx0, 0);

        // Pointer still at 0 after the commands: mask 0b11 picks sensor 1
        sensor_mask = 6'h03;
        enable      = 1'b1;
        wait_tx();
        check_val("rr_kept_tx_byte", tx_byte, 8'h01);
        enable = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rx_dv   = 1'b1;
        rx_byte = 8'h5A;
        tick();
        rx_dv = 1'b0;
        res0  = res_cnt;
        // Now waiting for the checksum byte: abort with reset
        reset = 1'b1;
        tick();
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_res_valid", res_valid, 1'b0);
        reset = 1'b0;
        repeat (2) tick();
        check_val("abort_no_result", res_cnt - res0, 0);
        enable = 1'b1;
        wait_tx();
        check_val("post_rst_tx_byte", tx_byte, 8'h00);
        enable = 1'b0;
        reply(8'h21, 8'h21 ^ 8'h37, 1'b1, 3'd0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
